// File: rtl/spi_ram_pkg.sv
// Command encodings and word widths shared by the SPI slave and the RAM controller.
package spi_ram_pkg;

    localparam int RX_W = 10;
    localparam int TX_W = 8;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port synchronous array: one write enable, registered read with its own enable, no reset.
// Read data updates only on i_re, so it holds across idle cycles and writes.
module spi_ram_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdat,
    output logic [DW-1:0] o_rdat
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdat;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdat;
        end
        if (i_re) begin
            r_rdat <= r_mem[i_addr];
        end
    end

    assign o_rdat = r_rdat;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command-decoded RAM behind the SPI slave: one command per rx_valid rising edge, read data on the next edge.
// Optional SPI_RAM_PARITY_EN: stores an even-parity bit per word and flags mismatches on read.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RX_W-1:0] rx_data,
    input  logic            rx_valid,
    output logic [TX_W-1:0] tx_data,
    output logic            tx_valid,
    output logic            parity_err
);

`ifdef SPI_RAM_PARITY_EN
    localparam int DW = 9;
`else
    localparam int DW = 8;
`endif
    localparam logic [ADDR_SIZE:0] DEPTH_L = (ADDR_SIZE+1)'(MEM_DEPTH);

    logic                 r_rxv_q;
    logic [ADDR_SIZE-1:0] r_wr_addr;
    logic [ADDR_SIZE-1:0] r_rd_addr;
    logic                 r_tx_vld;
    logic                 r_tx_zero;

    logic                 w_cmd_stb;
    cmd_e                 w_cmd;
    logic [ADDR_SIZE-1:0] w_addr;
    logic                 w_wr_in_rng;
    logic                 w_rd_in_rng;
    logic                 w_mem_we;
    logic                 w_mem_re;
    logic [ADDR_SIZE-1:0] w_mem_addr;
    logic [DW-1:0]        w_mem_wdat;
    logic [DW-1:0]        w_mem_rdat;

    assign w_cmd_stb   = rx_valid & ~r_rxv_q;
    assign w_cmd       = cmd_e'(rx_data[RX_W-1:RX_W-2]);
    assign w_addr      = rx_data[ADDR_SIZE-1:0];
    assign w_wr_in_rng = {1'b0, r_wr_addr} < DEPTH_L;
    assign w_rd_in_rng = {1'b0, r_rd_addr} < DEPTH_L;

`ifdef SPI_RAM_PARITY_EN
    assign w_mem_wdat = {even_par(rx_data[7:0]), rx_data[7:0]};
`else
    assign w_mem_wdat = rx_data[7:0];
`endif

    // Only one command per strobe, so the single port is shared between write and read addresses.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_re   = 1'b0;
        w_mem_addr = r_rd_addr;
        if (w_cmd_stb) begin
            case (w_cmd)
                CMD_WR_DATA: begin
                    w_mem_we   = w_wr_in_rng;
                    w_mem_addr = r_wr_addr;
                end
                CMD_RD_DATA: w_mem_re = w_rd_in_rng;
                default: ;
            endcase
        end
    end

    spi_ram_mem #(
        .DEPTH (MEM_DEPTH),
        .AW    (ADDR_SIZE),
        .DW    (DW)
    ) u_mem (
        .clk    (clk),
        .i_we   (w_mem_we),
        .i_re   (w_mem_re),
        .i_addr (w_mem_addr),
        .i_wdat (w_mem_wdat),
        .o_rdat (w_mem_rdat)
    );

    // r_rxv_q resets high so a level already present at reset release is not taken as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxv_q   <= 1'b1;
            r_wr_addr <= '0;
            r_rd_addr <= '0;
            r_tx_vld  <= 1'b0;
            r_tx_zero <= 1'b1;
        end else begin
            r_rxv_q <= rx_valid;
            if (w_cmd_stb) begin
                r_tx_vld <= (w_cmd == CMD_RD_DATA);
                case (w_cmd)
                    CMD_WR_ADDR: r_wr_addr <= w_addr;
                    CMD_RD_ADDR: r_rd_addr <= w_addr;
                    CMD_RD_DATA: r_tx_zero <= ~w_rd_in_rng;
                    default: ;
                endcase
            end
        end
    end

    assign tx_valid = r_tx_vld;
    assign tx_data  = r_tx_zero ? '0 : w_mem_rdat[TX_W-1:0];

`ifdef SPI_RAM_PARITY_EN
    logic r_par_chk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_chk <= 1'b0;
        end else if (w_cmd_stb) begin
            r_par_chk <= (w_cmd == CMD_RD_DATA) & w_rd_in_rng;
        end
    end

    assign parity_err = r_par_chk & (w_mem_rdat[8] != even_par(w_mem_rdat[7:0]));
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Randomised bench for spi_ram_ctrl (MEM_DEPTH=200) against a behavioural array model, plus directed literal checks.
module tb_spi_ram_ctrl;
    import spi_ram_pkg::*;

    localparam int DEPTH = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       parity_err;

    int checks = 0;
    int failures = 0;

    // Behavioural model: plain array plus the architectural registers the commands name.
    logic [7:0] m_mem [256];
    bit         m_bad [256];
    logic [7:0] m_wr = '0;
    logic [7:0] m_rd = '0;
    logic [7:0] m_td = '0;
    bit         m_tv = 1'b0;
    bit         m_pe = 1'b0;

    always #5 clk = ~clk;

    spi_ram_ctrl #(
        .MEM_DEPTH (DEPTH),
        .ADDR_SIZE (8)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .parity_err (parity_err)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%02h required=%02h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cyc_tx_valid", {7'b0, tx_valid}, {7'b0, m_tv});
        chk("cyc_tx_data", tx_data, m_td);
        chk("cyc_parity_err", {7'b0, parity_err}, {7'b0, m_pe});
    end

    task automatic model_apply(input logic [1:0] c, input logic [7:0] p);
        m_tv = (c == 2'b11);
        m_pe = 1'b0;
        case (c)
            2'b00: m_wr = p;
            2'b01: if (m_wr < DEPTH) begin
                m_mem[m_wr] = p;
                m_bad[m_wr] = 1'b0;
            end
            2'b10: m_rd = p;
            default: if (m_rd < DEPTH) begin
                m_td = m_mem[m_rd];
                m_pe = m_bad[m_rd];
            end else begin
                m_td = 8'h00;
            end
        endcase
    endtask

    task automatic model_reset();
        m_wr = '0;
        m_rd = '0;
        m_td = '0;
        m_tv = 1'b0;
        m_pe = 1'b0;
    endtask

    // Called at posedge+1 with rx_valid low in the previous cycle; returns at posedge+1 with rx_valid low.
    task automatic send(input logic [1:0] c, input logic [7:0] p, input int hold, input bit mutate);
        rx_data  = {c, p};
        rx_valid = 1'b1;
        @(posedge clk);
        model_apply(c, p);
        #1;
        for (int i = 1; i < hold; i++) begin
            if (mutate) rx_data = {2'b01, 8'($urandom)};
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_parity_err", {7'b0, parity_err}, 8'h00);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int a = 0; a < DEPTH; a++) begin
            send(CMD_WR_ADDR, 8'(a), 1, 1'b0);
            send(CMD_WR_DATA, 8'($urandom), 1, 1'b0);
        end

        // Write then read
        send(CMD_WR_ADDR, 8'h12, 1, 1'b0);
        send(CMD_WR_DATA, 8'hA5, 2, 1'b0);
        send(CMD_RD_ADDR, 8'h12, 1, 1'b0);
        send(CMD_RD_DATA, 8'h00, 1, 1'b0);
        chk("wr_rd_valid", {7'b0, tx_valid}, 8'h01);
        chk("wr_rd_data", tx_data, 8'hA5);

        // Held rx_valid with payload churn: exactly one write
        send(CMD_WR_ADDR, 8'h03, 1, 1'b0);
        send(CMD_WR_DATA, 8'h5A, 20, 1'b1);
        send(CMD_RD_ADDR, 8'h03, 3, 1'b0);
        send(CMD_RD_DATA, 8'h00, 5, 1'b0);
        chk("held_data", tx_data, 8'h5A);

        // tx_valid lifetime
        repeat (50) @(posedge clk);
        #1;
        chk("idle_valid", {7'b0, tx_valid}, 8'h01);
        send(CMD_WR_ADDR, 8'h20, 1, 1'b0);
        chk("clr_valid", {7'b0, tx_valid}, 8'h00);
        chk("clr_data_hold", tx_data, 8'h5A);
        send(CMD_RD_ADDR, 8'h12, 1, 1'b0);
        send(CMD_RD_DATA, 8'h00, 1, 1'b0);
        chk("b2b_first", tx_data, 8'hA5);
        send(CMD_RD_DATA, 8'h00, 1, 1'b0);
        chk("b2b_valid", {7'b0, tx_valid}, 8'h01);

        // Reset mid-operation with a held frame
        send(CMD_WR_ADDR, 8'h00, 1, 1'b0);
        send(CMD_WR_DATA, 8'h3C, 1, 1'b0);
        send(CMD_RD_ADDR, 8'h55, 1, 1'b0);
        send(CMD_RD_DATA, 8'h00, 1, 1'b0);
        chk("pre_rst_valid", {7'b0, tx_valid}, 8'h01);
        rx_data  = {CMD_WR_DATA, 8'hEE};
        rx_valid = 1'b1;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_valid", {7'b0, tx_valid}, 8'h00);
        chk("async_rst_data", tx_data, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_no_cmd", {7'b0, tx_valid}, 8'h00);
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        send(CMD_RD_DATA, 8'h00, 1, 1'b0);
        chk("post_rst_rd0", tx_data, 8'h3C);

        // Range boundaries
        send(CMD_WR_ADDR, 8'hF0, 1, 1'b0);
        send(CMD_WR_DATA, 8'h77, 1, 1'b0);
        send(CMD_RD_ADDR, 8'hF0, 1, 1'b0);
        send(CMD_RD_DATA, 8'h00, 1, 1'b0);
        chk("oor_data", tx_data, 8'h00);
        chk("oor_valid", {7'b0, tx_valid}, 8'h01);
        send(CMD_RD_ADDR, 8'h28, 1, 1'b0);
        send(CMD_RD_DATA, 8'h00, 1, 1'b0);
        send(CMD_WR_ADDR, 8'hC7, 1, 1'b0);
        send(CMD_WR_DATA, 8'h42, 1, 1'b0);
        send(CMD_RD_ADDR, 8'hC7, 1, 1'b0);
        send(CMD_RD_DATA, 8'h00, 1, 1'b0);
        chk("last_addr", tx_data, 8'h42);
        send(CMD_RD_ADDR, 8'hC8, 1, 1'b0);
        send(CMD_RD_DATA, 8'h00, 1, 1'b0);
        chk("first_oor", tx_data, 8'h00);

`ifdef SPI_RAM_PARITY_EN
        send(CMD_WR_ADDR, 8'h40, 1, 1'b0);
        send(CMD_WR_DATA, 8'h81, 1, 1'b0);
        u_dut.u_mem.r_mem[64][8] = ~u_dut.u_mem.r_mem[64][8];
        m_bad[64] = 1'b1;
        send(CMD_RD_ADDR, 8'h40, 1, 1'b0);
        send(CMD_RD_DATA, 8'h00, 1, 1'b0);
        chk("par_err_set", {7'b0, parity_err}, 8'h01);
        chk("par_err_data", tx_data, 8'h81);
        send(CMD_RD_ADDR, 8'h41, 1, 1'b0);
        send(CMD_RD_DATA, 8'h00, 1, 1'b0);
        chk("par_err_clean", {7'b0, parity_err}, 8'h00);
`endif

        for (int n = 0; n < 400; n++) begin
            logic [1:0] c;
            logic [7:0] p;
            c = 2'($urandom_range(0, 3));
            p = 8'($urandom_range(0, 255));
            send(c, p, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
